// File: rtl/y_mem_port_arbiter.sv
// y_mem_port_arbiter: round-robin share of the single-port Y memory between the
// write-back client (locked RMW) and the read client, with registered memory command.
module y_mem_port_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 256,
  parameter int MAX_LOCK = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_req,
  input  logic          i_wr_we,
  input  logic          i_wr_lock,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_wdata,
  output logic          o_wr_gnt,
  output logic          o_wr_rvalid,
  input  logic          i_rd_req,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_rd_gnt,
  output logic          o_rd_rvalid,
  output logic [DW-1:0] o_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_lock_timeout
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t        r_state;
  logic          r_last_wr;
  logic [CW-1:0] r_lock_cnt;
  logic          r_wr_tag, r_rd_tag, r_wr_rvalid, r_rd_rvalid, r_lock_timeout;
  logic          r_mem_en, r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          w_timeout, w_wr_gnt, w_rd_gnt;
  assign w_timeout = (r_state == LOCKED) && (r_lock_cnt == CW'(MAX_LOCK)) && i_wr_req;
  assign w_wr_gnt  = i_wr_req && ((r_state == LOCKED) ? !w_timeout : (!i_rd_req || !r_last_wr));
  assign w_rd_gnt  = i_rd_req && !w_wr_gnt && ((r_state == IDLE) || w_timeout);
  // Tags follow a read one stage behind the command so rvalid lines up with mem_rdata.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_last_wr      <= 1'b0;
      r_lock_cnt     <= '0;
      r_wr_tag       <= 1'b0;
      r_rd_tag       <= 1'b0;
      r_wr_rvalid    <= 1'b0;
      r_rd_rvalid    <= 1'b0;
      r_lock_timeout <= 1'b0;
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '1;
      r_mem_wdata    <= '0;
    end else begin
      r_mem_en    <= w_wr_gnt || w_rd_gnt;
      r_mem_we    <= w_wr_gnt && i_wr_we;
      r_mem_addr  <= w_wr_gnt ? i_wr_addr : w_rd_gnt ? i_rd_addr : '1;
      if (w_wr_gnt) r_mem_wdata <= i_wr_wdata;
      r_wr_tag    <= w_wr_gnt && !i_wr_we;
      r_rd_tag    <= w_rd_gnt;
      r_wr_rvalid <= r_wr_tag;
      r_rd_rvalid <= r_rd_tag;
      if (w_wr_gnt || w_rd_gnt) r_last_wr <= w_wr_gnt;
      if (w_timeout) r_lock_timeout <= 1'b1;
      // A locked grant never happens at cnt==MAX_LOCK, so the increment self-saturates.
      if (w_wr_gnt && i_wr_lock) begin
        r_state    <= LOCKED;
        r_lock_cnt <= r_lock_cnt + CW'(1);
      end else begin
        r_state    <= IDLE;
        r_lock_cnt <= '0;
      end
    end
  end
  assign o_wr_gnt       = w_wr_gnt;
  assign o_rd_gnt       = w_rd_gnt;
  assign o_wr_rvalid    = r_wr_rvalid;
  assign o_rd_rvalid    = r_rd_rvalid;
  assign o_rdata        = i_mem_rdata;
  assign o_mem_en       = r_mem_en;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_lock_timeout = r_lock_timeout;
endmodule

// File: tb/tb_y_mem_port_arbiter.sv
// tb_y_mem_port_arbiter: directed checks of arbitration, lock, timeout, read return and reset.
module tb_y_mem_port_arbiter;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         wr_req = 0, wr_we = 0, wr_lock = 0, rd_req = 0;
  logic [10:0]  wr_addr = 0, rd_addr = 0;
  logic [255:0] wr_wdata = 0, mem_rdata = 0;
  logic         wr_gnt, wr_rvalid, rd_gnt, rd_rvalid, mem_en, mem_we, lock_timeout;
  logic [10:0]  mem_addr;
  logic [255:0] rdata, mem_wdata;
  logic [255:0] mem [0:15];
  int           n_chk = 0, n_fail = 0;
  localparam logic [255:0] A = {8{32'hA5A5_0005}}, B = {8{32'hB0B0_0001}},
                           C = {8{32'hC0C0_0002}}, D = {8{32'hD0D0_0009}}, E = {8{32'hE0E0_0009}};

  y_mem_port_arbiter #(.AW(11), .DW(256), .MAX_LOCK(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(wr_req), .i_wr_we(wr_we), .i_wr_lock(wr_lock), .i_wr_addr(wr_addr),
    .i_wr_wdata(wr_wdata), .o_wr_gnt(wr_gnt), .o_wr_rvalid(wr_rvalid),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_gnt(rd_gnt), .o_rd_rvalid(rd_rvalid),
    .o_rdata(rdata), .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[1] = B; mem[2] = C; mem[5] = A; mem[9] = E;
  end

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[3:0]];
    end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #22;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 11'h7ff);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rvalid", {wr_rvalid, rd_rvalid}, 0);
    chk("rst_timeout", lock_timeout, 0);
    rst_n = 1;
    // idle: nothing granted, memory parked
    for (int i = 0; i < 10; i++) begin
      tick; #1;
      chk("idle_gnt", {wr_gnt, rd_gnt}, 0);
      chk("idle_mem", {mem_en, mem_we, mem_addr}, {2'b00, 11'h7ff});
      chk("idle_rvalid", {wr_rvalid, rd_rvalid}, 0);
    end
    // single read
    tick; rd_req = 1; rd_addr = 5; #1;
    chk("t1_gnt", {wr_gnt, rd_gnt}, 2'b01);
    tick; rd_req = 0; #1;
    chk("t1_mem", {mem_en, mem_we, mem_addr}, {2'b10, 11'd5});
    chk("t1_early_rvalid", rd_rvalid, 0);
    tick; #1;
    chk("t1_rvalid", {wr_rvalid, rd_rvalid}, 2'b01);
    chk("t1_rdata", rdata, A);
    tick; #1;
    chk("t1_rvalid_pulse", rd_rvalid, 0);
    // alternating tie (last winner was rd)
    for (int i = 0; i < 6; i++) begin
      tick;
      wr_req = (i < 4); wr_we = 0; wr_addr = 1; rd_req = (i < 4); rd_addr = 2;
      #1;
      if (i < 4) chk("t2_gnt", {wr_gnt, rd_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i >= 2) begin
        chk("t2_rvalid", {wr_rvalid, rd_rvalid}, (i % 2 == 0) ? 2'b10 : 2'b01);
        chk("t2_rdata", rdata, (i % 2 == 0) ? B : C);
      end
    end
    // RMW of row 9 with rd waiting
    tick; wr_req = 1; wr_we = 0; wr_lock = 1; wr_addr = 9; rd_req = 1; rd_addr = 5; #1;
    chk("t3_rd_gnt", {wr_gnt, rd_gnt}, 2'b10);
    tick; wr_we = 1; wr_lock = 0; wr_wdata = D; #1;
    chk("t3_wr_gnt", {wr_gnt, rd_gnt}, 2'b10);
    chk("t3_mem_rd9", {mem_en, mem_we, mem_addr}, {2'b10, 11'd9});
    tick; wr_req = 0; wr_we = 0; #1;
    chk("t3_rd_after", {wr_gnt, rd_gnt}, 2'b01);
    chk("t3_mem_wr9", {mem_en, mem_we, mem_addr}, {2'b11, 11'd9});
    chk("t3_wdata", mem_wdata, D);
    chk("t3_wr_rvalid", {wr_rvalid, rd_rvalid}, 2'b10);
    chk("t3_rdata9", rdata, E);
    tick; rd_req = 0; #1;
    chk("t3_mem_rd5", {mem_en, mem_we, mem_addr}, {2'b10, 11'd5});
    chk("t3_no_rvalid", {wr_rvalid, rd_rvalid}, 0);
    tick; #1;
    chk("t3_rd_rvalid", {wr_rvalid, rd_rvalid}, 2'b01);
    chk("t3_rdata5", rdata, A);
    // lock timeout with MAX_LOCK=4
    for (int i = 0; i < 6; i++) begin
      tick;
      wr_req = (i < 5); wr_we = 0; wr_lock = 1; wr_addr = 3; rd_req = (i < 5); rd_addr = 5;
      #1;
      if (i < 4) chk("t4_wr_gnt", {wr_gnt, rd_gnt}, 2'b10);
      if (i == 4) chk("t4_rd_gnt", {wr_gnt, rd_gnt}, 2'b01);
      chk("t4_timeout", lock_timeout, i == 5);
    end
    wr_lock = 0;
    repeat (4) tick;
    chk("t4_sticky", lock_timeout, 1);
    // reset in the cycle after a read grant
    tick; rd_req = 1; rd_addr = 5; #1;
    chk("t5_gnt", {wr_gnt, rd_gnt}, 2'b01);
    tick; rd_req = 0; #1;
    chk("t5_mem_en", mem_en, 1);
    rst_n = 0; #1;
    chk("t5_rst_mem", {mem_en, mem_we, mem_addr}, {2'b00, 11'h7ff});
    chk("t5_rst_timeout", lock_timeout, 0);
    tick; #1;
    chk("t5_no_rvalid", {wr_rvalid, rd_rvalid}, 0);
    rst_n = 1;
    tick; #1;
    chk("t5_no_rvalid2", {wr_rvalid, rd_rvalid}, 0);
    // first tie after reset goes to wr
    tick; wr_req = 1; wr_we = 0; wr_addr = 1; rd_req = 1; #1;
    chk("t5_first_tie", {wr_gnt, rd_gnt}, 2'b10);
    tick; wr_req = 0; rd_req = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
